// File: rtl/riscv_div_ctrl.sv
`default_nettype none
// ============================================================================
// riscv_div_ctrl : RV32M DIV/DIVU/REM/REMU radix-2 restoring sequencer (EX)
// Option: RISCV_DIV_EARLY_OUT_EN (skip iterations when |a| < |b|)  Rev 1.0
// ============================================================================
module riscv_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_valid_e,
  input  logic [1:0]      i_div_op_e,
  input  logic [XLEN-1:0] i_src_a_e,
  input  logic [XLEN-1:0] i_src_b_e,
  input  logic            i_flush_e,
  output logic            o_stall_div,
  output logic            o_div_busy,
  output logic            o_div_done,
  output logic [XLEN-1:0] o_div_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_stall;
  logic            w_done;

  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_dvsr;
  logic [XLEN-1:0] r_quo;
  logic [XLEN:0]   r_rem;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  // Operand decode for the accepting IDLE cycle
  logic            w_is_signed;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg_q_in;
  logic            w_neg_r_in;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_early;
  logic            w_special;
  logic            w_accept;
  logic [XLEN-1:0] w_special_result;

  assign w_is_signed = ~i_div_op_e[0];
  assign w_abs_a     = (w_is_signed & i_src_a_e[XLEN-1]) ? -i_src_a_e : i_src_a_e;
  assign w_abs_b     = (w_is_signed & i_src_b_e[XLEN-1]) ? -i_src_b_e : i_src_b_e;
  assign w_neg_q_in  = w_is_signed & (i_src_a_e[XLEN-1] ^ i_src_b_e[XLEN-1]);
  assign w_neg_r_in  = w_is_signed & i_src_a_e[XLEN-1];
  assign w_div_zero  = (i_src_b_e == '0);
  assign w_ovf       = w_is_signed & (i_src_a_e == C_MIN_NEG) & (i_src_b_e == '1);

`ifdef RISCV_DIV_EARLY_OUT_EN
  assign w_early = ~w_div_zero & (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_special = w_div_zero | w_ovf | w_early;
  assign w_accept  = (r_state == IDLE) & i_div_valid_e & ~i_flush_e;

  // Special cases bypass sign correction; early-out (q=0, r=|a|) does not
  always_comb begin
    w_special_result = '0;
    if (w_div_zero) begin
      w_special_result = i_div_op_e[1] ? i_src_a_e : '1;
    end else if (w_ovf) begin
      w_special_result = i_div_op_e[1] ? '0 : C_MIN_NEG;
    end else if (w_early) begin
      w_special_result = i_div_op_e[1] ? (w_neg_r_in ? -w_abs_a : w_abs_a) : '0;
    end
  end

  // Restoring step; one extra guard bit makes the borrow the difference's MSB
  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;
  logic [XLEN:0]   w_rem_step;
  logic [XLEN-1:0] w_quo_step;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic            w_last;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {2'b00, r_dvsr};
  assign w_borrow   = w_diff[XLEN+1];
  assign w_rem_step = w_borrow ? w_shift[XLEN:0] : w_diff[XLEN:0];
  assign w_quo_step = {r_quo[XLEN-2:0], ~w_borrow};
  assign w_q_fix    = r_neg_q ? -w_quo_step : w_quo_step;
  assign w_r_fix    = r_neg_r ? -w_rem_step[XLEN-1:0] : w_rem_step[XLEN-1:0];
  assign w_last     = (r_cnt == CW'(XLEN-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = i_div_valid_e & ~i_flush_e;
        if (w_accept) begin
          w_state_nxt = w_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_stall = ~i_flush_e;
        if (i_flush_e) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // The instruction still in EX is the one just finished: never re-accept
        w_done      = ~i_flush_e;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvsr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_rem <= i_div_op_e[1];
            r_neg_q  <= w_neg_q_in;
            r_neg_r  <= w_neg_r_in;
            r_dvsr   <= w_abs_b;
            r_quo    <= w_abs_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_special) begin
              r_result <= w_special_result;
            end
          end
        end
        BUSY: begin
          r_quo <= w_quo_step;
          r_rem <= w_rem_step;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= r_is_rem ? w_r_fix : w_q_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_stall_div  = w_stall & ~i_rst;
  assign o_div_busy   = (r_state != IDLE);
  assign o_div_done   = w_done;
  assign o_div_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_riscv_div_ctrl : scoreboard bench for riscv_div_ctrl (result + latency)
// Rev 1.0
// ============================================================================
module tb_riscv_div_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            div_valid;
  logic [1:0]      div_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            stall_div;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  riscv_div_ctrl #(.XLEN(XLEN)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_div_valid_e(div_valid),
    .i_div_op_e   (div_op),
    .i_src_a_e    (src_a),
    .i_src_b_e    (src_b),
    .i_flush_e    (flush),
    .o_stall_div  (stall_div),
    .o_div_busy   (div_busy),
    .o_div_done   (div_done),
    .o_div_result (div_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_ops    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    bit is_rem = op[1];
    bit sgn    = !op[0];
    int sa;
    int sbv;
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) begin
      sa  = a;
      sbv = b;
      return is_rem ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Number of cycles o_stall_div is high before the DONE cycle
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    bit sgn = !op[0];
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    mag_a = (sgn && a[31]) ? -a : a;
    mag_b = (sgn && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RISCV_DIV_EARLY_OUT_EN
    if (mag_a < mag_b) return 1;
`else
    if (mag_a < mag_b) return XLEN + 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a result
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (div_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 required=0 result=0x%08h", div_result);
        end else begin
          e = sb.pop_front();
          check($sformatf("result[%0d]", e.id), div_result, e.res);
          check($sformatf("stall_cycles[%0d]", e.id), 32'(stall_cnt), 32'(e.lat));
        end
        stall_cnt = 0;
      end else if (stall_div) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
      end
    end
  end

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE after DONE
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   got;
    e.res = ref_div(op, a, b);
    e.lat = ref_lat(op, a, b);
    e.id  = n_ops;
    n_ops++;
    sb.push_back(e);
    div_valid = 1'b1;
    div_op    = op;
    src_a     = a;
    src_b     = b;
    got       = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (div_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout[%0d] actual=no_done required=done", e.id);
    end
    @(posedge clk);
    #1;
    check($sformatf("idle_after[%0d]", e.id), {30'd0, div_busy, div_done}, 32'd0);
    div_valid = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    div_valid = 1'b1;
    div_op    = 2'b00;
    src_a     = 32'd100;
    src_b     = 32'd7;
    flush     = 1'b0;

    // Reset with a divide presented: nothing may start or stall
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, stall_div}, 32'd0);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    check("reset_done", {31'd0, div_done}, 32'd0);
    check("reset_result", div_result, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    div_valid = 1'b0;
    @(posedge clk);
    #1;

    run_op(2'b00, 32'd100, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b01, 32'd1234, 32'd0);
    run_op(2'b11, 32'd1234, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd9);

    // Flush in IDLE: no accept
    div_valid = 1'b1; div_op = 2'b01; src_a = 32'd1000; src_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall_div}, 32'd0);
    @(posedge clk);
    #1;
    check("flush_idle_busy", {31'd0, div_busy}, 32'd0);
    div_valid = 1'b0; flush = 1'b0;

    // Flush in the 10th BUSY cycle
    div_valid = 1'b1; div_op = 2'b01; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_stall", {31'd0, stall_div}, 32'd0);
    @(posedge clk);
    #1;
    div_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {30'd0, div_busy, div_done}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Reset in the 10th BUSY cycle
    div_valid = 1'b1; div_op = 2'b01; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_stall", {31'd0, stall_div}, 32'd0);
    check("rst_busy_done", {31'd0, div_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; div_valid = 1'b0;
    @(negedge clk);
    check("rst_after_flags", {29'd0, stall_div, div_busy, div_done}, 32'd0);
    check("rst_after_result", div_result, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Flush in DONE suppresses the done pulse
    div_valid = 1'b1; div_op = 2'b01; src_a = 32'd1234; src_b = 32'd0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_done", {31'd0, div_done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; div_valid = 1'b0;
    check("flush_done_busy", {31'd0, div_busy}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = rand_operand();
      rb  = rand_operand();
      run_op(rop, ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_div_ctrl.md
Name: riscv_div_ctrl

Overview:
- Iterative divide sequencer for the RV32M DIV/DIVU/REM/REMU group in the EX stage of the pipelined core.
- Accepts an EX-stage divide, runs a radix-2 restoring divider, and holds the pipeline with a stall request (OR'd into the F/D/E stall terms beside the hazard unit) until the result is ready.
- Handles the architectural special cases. Aborts on an EX flush.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_div_valid_e  input  1  instruction in EX is a divide/remainder.
- i_div_op_e  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_src_a_e  input  XLEN  dividend (post-forwarding).
- i_src_b_e  input  XLEN  divisor (post-forwarding).
- i_flush_e  input  1  EX flush; kills the operation in progress.
- o_stall_div  output  1  freeze F, D, E (combinational).
- o_div_busy  output  1  FSM not IDLE (registered state decode).
- o_div_done  output  1  o_div_result valid this cycle; EX may advance.
- o_div_result  output  XLEN  quotient or remainder per latched op.

Behaviour:
- Reset (sync, i_rst=1): state IDLE, counter 0, operand/quotient/remainder registers 0.
- Reset values: o_div_busy=0, o_div_done=0, o_div_result=0. o_stall_div is forced 0 while i_rst=1.
- Reset mid-operation returns to IDLE next edge. No result is produced.

States: IDLE, BUSY, DONE.

IDLE:
- o_stall_div = i_div_valid_e & ~i_flush_e.
- On accept, latch op, sign flags, |a|, |b|. Absolute values apply only for signed ops DIV/REM.
- Divisor == 0: precompute q = all-ones, r = a; go DONE.
- Signed op with a == 0x80000000 and b == 0xFFFFFFFF: precompute q = 0x80000000, r = 0; go DONE.
- Otherwise: clear counter and remainder; go BUSY.

BUSY:
- o_stall_div=1.
- One restoring step per cycle: shift {rem,quo} left 1, trial-subtract |b|, set quotient bit if there is no borrow. Counter increments each cycle.
- After XLEN cycles (counter == XLEN-1 on the transition edge), go DONE.

DONE:
- o_stall_div=0, o_div_done=1.
- o_div_result is registered. For signed ops the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign. Special-case values pass through uncorrected.
- Always go IDLE next edge. i_div_valid_e still high this cycle is the same instruction and must not restart the divider.

Latency:
- Normal op: o_stall_div high for 1 + XLEN = 33 cycles, then 1 DONE cycle. The instruction sits in EX for 34 cycles.
- Special cases: 1 stall cycle, then DONE.

Flush:
- i_flush_e in IDLE: no accept, stall 0.
- i_flush_e in BUSY: o_stall_div=0 in that cycle; go IDLE.
- i_flush_e in DONE: o_div_done suppressed to 0; go IDLE.
- Flush has priority over every other transition.

Back-to-back: a new divide can be accepted in the IDLE cycle that follows DONE.

Width rules: remainder register is XLEN+1 bits for the trial subtraction. All negation is two's complement modulo 2^XLEN.

Optional Feature:
- Macro: RISCV_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |a| < |b| (unsigned compare of the magnitudes), skip BUSY. Set q = 0, r = |a|, then go DONE with normal sign correction. Result: 1 stall cycle.
- Not defined: such operands take the full XLEN-cycle BUSY path. Results are identical either way.

Test Plan:
- DIV 100 / 7 (op 00), valid held → o_stall_div high 33 cycles; DONE cycle o_div_result=14, o_div_done=1 for exactly 1 cycle; IDLE after.
- REM -7 / 2 (0xFFFFFFF9, 2, op 10) → o_div_result=0xFFFFFFFF; DIV same operands → 0xFFFFFFFD.
- DIVU 1234 / 0 → 1 stall cycle, o_div_result=0xFFFFFFFF; REMU 1234 / 0 → 1234.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 after 1 stall cycle; REM same → 0; DIVU same → 0 after the full 33-cycle stall.
- Start DIVU 1000 / 3, assert i_flush_e in the 10th BUSY cycle → o_stall_div=0 that cycle, o_div_busy=0 next cycle, no o_div_done. Repeat the test with i_rst in place of the flush: same response and all outputs 0.
- REMU 5 / 9 → result 5. With RISCV_DIV_EARLY_OUT_EN: 1 stall cycle. Without the macro: 33 stall cycles.
